div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
- Shares one Goldschmidt divider instance among NREQ requesters, e.g. the FP divide, the fixed-point divide and the reciprocal-estimate paths.
- Arbitrates round-robin, then sequences the divider: load pulse, wait for done, capture the result.
- Returns a tagged result through a valid/ready response port.
- Screens out divide-by-zero without occupying the divider.

Parameters:
- FPWID, 32, operand width; the divider result is 2*FPWID.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester index, clog2(NREQ).
- TIMEOUT, 64, watchdog limit in cycles for the divider done (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester request, level; held until ack
- req_a  in  NREQ*FPWID  packed dividends; requester i occupies bits [i*FPWID +: FPWID]
- req_b  in  NREQ*FPWID  packed divisors; same packing
- ack  out  NREQ  one-hot, one-cycle grant pulse; operands are captured on this cycle
- div_ld  out  1  load strobe to the divider
- div_a  out  FPWID  dividend to the divider
- div_b  out  FPWID  divisor to the divider
- div_q  in  2*FPWID  divider quotient
- div_lzcnt  in  8  divider leading-zero count of the quotient
- div_done  in  1  divider completion pulse
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts the response
- resp_id  out  IDW  index of the requester that owns the response
- resp_q  out  2*FPWID  quotient
- resp_lzcnt  out  8  leading-zero count
- resp_dvz  out  1  divide-by-zero flag
- resp_err  out  1  timeout flag (0 when the optional feature is compiled out)

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant = NREQ-1, so requester 0 wins first. Reset mid-operation aborts any transaction; the divider is expected to share rst.
- IDLE:
  - If any req is high, the winner is the first set bit scanning from last_grant+1, wrapping modulo NREQ.
  - In that same cycle: ack[winner]=1; latch the winner's a/b into div_a/div_b; latch the index; last_grant <= winner.
  - If the latched b==0, go to RESP with resp_dvz=1, resp_q all ones, resp_lzcnt=0. The divider is not loaded.
  - Otherwise go to LOAD.
- LOAD: div_ld=1 for exactly one cycle; then go to WAIT and clear the cycle counter.
- WAIT:
  - div_a/div_b stay stable.
  - On div_done, capture div_q and div_lzcnt into resp_q and resp_lzcnt; go to RESP.
  - div_done seen in any state other than WAIT is ignored.
- RESP:
  - resp_valid=1; resp_* held stable while resp_valid && !resp_ready.
  - On resp_valid && resp_ready, drop resp_valid, clear resp_dvz and resp_err, go to IDLE.
  - No new grant is issued in the handshake cycle. The next grant comes at the earliest one cycle later.
- Latency, req to resp_valid: 1 (grant) + 1 (load) + divider cycles + 1. Divide-by-zero responds 1 cycle after the grant.
- Requests arriving while not in IDLE wait. ack never asserts outside IDLE. At most one transaction is in flight.
- Simultaneous events:
  - A req deasserted before its ack is simply not granted.
  - div_done in the same cycle as a timeout expiry: done wins and resp_err=0.

Optional Feature:
- Macro: DIV_SHARE_TIMEOUT_EN.
- Defined:
  - WAIT counts cycles in a counter of clog2(TIMEOUT)+1 bits.
  - If the count reaches TIMEOUT-1 with no div_done, go to RESP with resp_err=1 and resp_q=0.
  - A late div_done is ignored, as is any div_done outside WAIT.
- Not defined: no counter exists; WAIT waits indefinitely; resp_err is tied to 0.

Test Plan:
- Single transaction. Bench divider model pulses done 5 cycles after ld and returns q={a,b}. req[1]=1 with a=0x00030000, b=0x00010000 -> ack[1] one cycle; div_ld one cycle later; resp_valid 7 cycles after ack, resp_id=1, resp_q=0x0003000000010000, resp_dvz=0.
- Round-robin. req=4'b1111 held, each response accepted immediately -> grant order 0,1,2,3,0. ack is never asserted while resp_valid=1.
- Divide-by-zero. req[2]=1, b=0 -> resp_valid the cycle after ack, resp_dvz=1, resp_q=all ones, div_ld never asserted.
- Backpressure. resp_ready held low 10 cycles with req[0] pending -> resp_* stable for all 10 cycles and no ack. Raising resp_ready gives one accepted response, then ack[0] one cycle later.
- Timeout (DIV_SHARE_TIMEOUT_EN, TIMEOUT=64). Model never asserts done -> resp_err=1, resp_q=0 exactly 64 cycles after div_ld. A spurious div_done afterwards is ignored.
- Reset mid-WAIT. rst pulses 1 cycle -> all outputs 0. The next request from requester 0 is granted first.

Source files
------------

// File: rtl/div_share_arbiter.sv
// Round-robin front end sharing one Goldschmidt divider among NREQ requesters.
// Optional divider watchdog enabled by defining DIV_SHARE_TIMEOUT_EN.
module div_share_arbiter #(
  parameter int FPWID   = 32,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*FPWID-1:0]  req_a,
  input  logic [NREQ*FPWID-1:0]  req_b,
  output logic [NREQ-1:0]        ack,
  output logic                   div_ld,
  output logic [FPWID-1:0]       div_a,
  output logic [FPWID-1:0]       div_b,
  input  logic [2*FPWID-1:0]     div_q,
  input  logic [7:0]             div_lzcnt,
  input  logic                   div_done,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [2*FPWID-1:0]     resp_q,
  output logic [7:0]             resp_lzcnt,
  output logic                   resp_dvz,
  output logic                   resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [IDW-1:0]       r_last;
  logic [IDW-1:0]       r_id;
  logic [FPWID-1:0]     r_div_a;
  logic [FPWID-1:0]     r_div_b;
  logic                 r_resp_valid;
  logic [2*FPWID-1:0]   r_resp_q;
  logic [7:0]           r_resp_lzcnt;
  logic                 r_resp_dvz;
  logic                 w_any;
  logic [IDW-1:0]       w_win;
  logic [IDW-1:0]       w_scan_idx;
  logic                 w_tmo;
  logic [FPWID-1:0]     w_a [NREQ];
  logic [FPWID-1:0]     w_b [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_a[gi] = req_a[gi*FPWID +: FPWID];
    assign w_b[gi] = req_b[gi*FPWID +: FPWID];
  end

  // Scan starts one past the previous winner so every requester gets a turn.
  always_comb begin
    w_any      = 1'b0;
    w_win      = '0;
    w_scan_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_scan_idx = IDW'((int'(r_last) + k) % NREQ);
      if (!w_any && req[w_scan_idx]) begin
        w_any = 1'b1;
        w_win = w_scan_idx;
      end
    end
  end

`ifdef DIV_SHARE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_resp_err;

  assign w_cnt_next = r_cnt + 1'b1;
  assign w_tmo      = (w_cnt_next == CW'(TIMEOUT - 1));
  assign resp_err   = r_resp_err;
`else
  assign w_tmo      = 1'b0;
  assign resp_err   = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    ack          = '0;
    div_ld       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any && !rst) begin
          ack[w_win]   = 1'b1;
          w_state_next = (w_b[w_win] == '0) ? S_RESP : S_LOAD;
        end
      end
      S_LOAD: begin
        div_ld       = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (div_done || w_tmo) w_state_next = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last       <= IDW'(NREQ - 1);
      r_id         <= '0;
      r_div_a      <= '0;
      r_div_b      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_q     <= '0;
      r_resp_lzcnt <= '0;
      r_resp_dvz   <= 1'b0;
`ifdef DIV_SHARE_TIMEOUT_EN
      r_cnt        <= '0;
      r_resp_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_div_a <= w_a[w_win];
            r_div_b <= w_b[w_win];
            r_id    <= w_win;
            r_last  <= w_win;
            // A zero divisor is answered directly, the divider stays idle.
            if (w_b[w_win] == '0) begin
              r_resp_valid <= 1'b1;
              r_resp_dvz   <= 1'b1;
              r_resp_q     <= '1;
              r_resp_lzcnt <= '0;
            end
          end
        end
        S_LOAD: begin
`ifdef DIV_SHARE_TIMEOUT_EN
          r_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (div_done) begin
            r_resp_valid <= 1'b1;
            r_resp_q     <= div_q;
            r_resp_lzcnt <= div_lzcnt;
          end
`ifdef DIV_SHARE_TIMEOUT_EN
          else if (w_tmo) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_q     <= '0;
            r_resp_lzcnt <= '0;
          end else begin
            r_cnt <= w_cnt_next;
          end
`endif
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_dvz   <= 1'b0;
`ifdef DIV_SHARE_TIMEOUT_EN
            r_resp_err   <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign div_a      = r_div_a;
  assign div_b      = r_div_b;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_id;
  assign resp_q     = r_resp_q;
  assign resp_lzcnt = r_resp_lzcnt;
  assign resp_dvz   = r_resp_dvz;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a 5-cycle divider model returning {a,b}.
module tb_div_share_arbiter;
  localparam int FPWID = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*FPWID-1:0] req_a;
  logic [NREQ*FPWID-1:0] req_b;
  logic [NREQ-1:0]       ack;
  logic                  div_ld;
  logic [FPWID-1:0]      div_a;
  logic [FPWID-1:0]      div_b;
  logic [2*FPWID-1:0]    div_q;
  logic [7:0]            div_lzcnt;
  logic                  div_done;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [2*FPWID-1:0]    resp_q;
  logic [7:0]            resp_lzcnt;
  logic                  resp_dvz;
  logic                  resp_err;

  int checks   = 0;
  int failures = 0;
  int ld_count = 0;

  logic       m_done;
  logic       spur_done;
  logic       mute;
  logic [3:0] m_cnt;

  always #5 clk = ~clk;

  assign div_done = m_done | spur_done;

  div_share_arbiter #(.FPWID(FPWID), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .ack(ack),
    .div_ld(div_ld), .div_a(div_a), .div_b(div_b), .div_q(div_q),
    .div_lzcnt(div_lzcnt), .div_done(div_done), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_q(resp_q),
    .resp_lzcnt(resp_lzcnt), .resp_dvz(resp_dvz), .resp_err(resp_err)
  );

  function automatic logic [7:0] clz64(input logic [63:0] v);
    logic [7:0] n;
    logic       seen;
    n = 8'd0;
    seen = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) seen = 1'b1;
      if (!seen) n = n + 8'd1;
    end
    return n;
  endfunction

  // Divider model: done pulses 5 cycles after the load strobe.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 4'd0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (div_ld) begin
        ld_count <= ld_count + 1;
        if (!mute) begin
          m_cnt     <= 4'd5;
          div_q     <= {div_a, div_b};
          div_lzcnt <= clz64({div_a, div_b});
        end
      end else if (m_cnt != 4'd0) begin
        m_cnt <= m_cnt - 4'd1;
        if (m_cnt == 4'd2) m_done <= 1'b1;
      end
    end
  end

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*FPWID +: FPWID] = a;
    req_b[i*FPWID +: FPWID] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    resp_ready = 1'b0;
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ack, div_ld, resp_valid, resp_dvz, resp_err} !== 8'd0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {ack, div_ld, resp_valid, resp_dvz, resp_err});
    end
    checks++;
    if ({div_a, div_b, resp_q, resp_lzcnt, resp_id} !== '0) begin
      failures++;
      $display("FAIL reset_data div_a=%h div_b=%h resp_q=%h exp=0", div_a, div_b, resp_q);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_single();
    int k;
    set_op(1, 32'h00030000, 32'h00010000);
    @(negedge clk); req = 4'b0010; #1;
    checks++;
    if (ack !== 4'b0010) begin failures++; $display("FAIL single_ack got=%b exp=0010", ack); end
    @(negedge clk); req = '0; #1;
    checks++;
    if (div_ld !== 1'b1 || div_a !== 32'h00030000 || div_b !== 32'h00010000) begin
      failures++;
      $display("FAIL single_load ld=%b a=%h b=%h exp 1/00030000/00010000", div_ld, div_a, div_b);
    end
    k = 1;
    while (!resp_valid && k < 40) begin @(negedge clk); #1; k++; end
    checks++;
    if (k !== 7) begin failures++; $display("FAIL single_latency got=%0d exp=7", k); end
    checks++;
    if (resp_id !== 2'd1 || resp_q !== 64'h0003000000010000 || resp_lzcnt !== 8'd14
        || resp_dvz !== 1'b0 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL single_resp id=%0d q=%h lz=%0d dvz=%b err=%b exp 1/0003000000010000/14/0/0",
               resp_id, resp_q, resp_lzcnt, resp_dvz, resp_err);
    end
    resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0; #1;
    checks++;
    if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_accept valid=%b exp=0", resp_valid); end
    $display("single: id=%0d q=%h latency=%0d", resp_id, resp_q, k);
  endtask

  task automatic test_round_robin();
    logic [3:0] got [5];
    logic [3:0] expv [5];
    int n, cyc, overlap, k;
    expv[0] = 4'b0001; expv[1] = 4'b0010; expv[2] = 4'b0100; expv[3] = 4'b1000; expv[4] = 4'b0001;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'd1);
    resp_ready = 1'b1;
    @(negedge clk); req = 4'b1111;
    n = 0; cyc = 0; overlap = 0;
    while (n < 5 && cyc < 200) begin
      #1;
      if (ack != 4'b0000 && resp_valid) overlap++;
      if (ack != 4'b0000) begin got[n] = ack; n++; end
      @(negedge clk);
      cyc++;
    end
    req = '0;
    checks++;
    if (n !== 5) begin failures++; $display("FAIL rr_count got=%0d exp=5", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== expv[i]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, got[i], expv[i]); end
      else $display("rr: grant %0d ack=%b", i, got[i]);
    end
    checks++;
    if (overlap !== 0) begin failures++; $display("FAIL rr_ack_during_resp got=%0d exp=0", overlap); end
    k = 0;
    #1;
    while (!resp_valid && k < 40) begin @(negedge clk); #1; k++; end
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_q !== 64'h0000000100000001) begin
      failures++;
      $display("FAIL rr_last_resp valid=%b id=%0d q=%h exp 1/0/0000000100000001", resp_valid, resp_id, resp_q);
    end
    @(negedge clk); resp_ready = 1'b0;
  endtask

  task automatic test_dvz();
    int ld0;
    ld0 = ld_count;
    set_op(2, 32'h00001234, 32'h0);
    @(negedge clk); req = 4'b0100; #1;
    checks++;
    if (ack !== 4'b0100) begin failures++; $display("FAIL dvz_ack got=%b exp=0100", ack); end
    @(negedge clk); req = '0; #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_dvz !== 1'b1 || resp_q !== 64'hFFFFFFFFFFFFFFFF
        || resp_lzcnt !== 8'd0 || resp_id !== 2'd2 || div_ld !== 1'b0) begin
      failures++;
      $display("FAIL dvz_resp valid=%b dvz=%b q=%h lz=%0d id=%0d ld=%b exp 1/1/ffffffffffffffff/0/2/0",
               resp_valid, resp_dvz, resp_q, resp_lzcnt, resp_id, div_ld);
    end
    checks++;
    if (ld_count !== ld0) begin failures++; $display("FAIL dvz_no_load got=%0d exp=%0d", ld_count, ld0); end
    resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0; #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_dvz !== 1'b0) begin
      failures++;
      $display("FAIL dvz_clear valid=%b dvz=%b exp 0/0", resp_valid, resp_dvz);
    end
    $display("dvz: requester 2 answered without divider");
  endtask

  task automatic test_backpressure();
    int bad, k;
    set_op(3, 32'd7, 32'd0);
    set_op(0, 32'd9, 32'd3);
    @(negedge clk); req = 4'b1000; #1;
    checks++;
    if (ack !== 4'b1000) begin failures++; $display("FAIL bp_ack3 got=%b exp=1000", ack); end
    @(negedge clk); req = 4'b0001; #1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (ack !== 4'b0000 || resp_valid !== 1'b1 || resp_id !== 2'd3
          || resp_q !== 64'hFFFFFFFFFFFFFFFF || resp_dvz !== 1'b1) bad++;
      @(negedge clk); #1;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL bp_stable got=%0d bad cycles exp=0", bad); end
    resp_ready = 1'b1; #1;
    checks++;
    if (ack !== 4'b0000 || resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_handshake ack=%b valid=%b exp 0000/1", ack, resp_valid);
    end
    @(negedge clk); resp_ready = 1'b0; #1;
    checks++;
    if (ack !== 4'b0001 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_next_grant ack=%b valid=%b exp 0001/0", ack, resp_valid);
    end
    @(negedge clk); req = '0; #1;
    k = 0;
    while (!resp_valid && k < 40) begin @(negedge clk); #1; k++; end
    checks++;
    if (resp_id !== 2'd0 || resp_q !== 64'h0000000900000003 || resp_lzcnt !== 8'd28) begin
      failures++;
      $display("FAIL bp_resp0 id=%0d q=%h lz=%0d exp 0/0000000900000003/28", resp_id, resp_q, resp_lzcnt);
    end
    resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0;
    $display("backpressure: held 10 cycles then requester 0 served");
  endtask

  task automatic test_reset_mid_wait();
    int k;
    set_op(0, 32'h00000100, 32'h00000010);
    set_op(1, 32'h00000200, 32'h00000020);
    @(negedge clk); req = 4'b0001;
    @(negedge clk); req = '0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({ack, div_ld, resp_valid, resp_dvz, resp_err} !== 8'd0 || {div_a, div_b, resp_q} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs ctrl=%b a=%h b=%h q=%h exp 0",
               {ack, div_ld, resp_valid, resp_dvz, resp_err}, div_a, div_b, resp_q);
    end
    spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0; #1;
    checks++;
    if (resp_valid !== 1'b0) begin failures++; $display("FAIL spurious_idle valid=%b exp=0", resp_valid); end
    @(negedge clk); req = 4'b0011; #1;
    checks++;
    if (ack !== 4'b0001) begin failures++; $display("FAIL midreset_first_grant got=%b exp=0001", ack); end
    @(negedge clk); req = '0; #1;
    k = 0;
    while (!resp_valid && k < 40) begin @(negedge clk); #1; k++; end
    checks++;
    if (resp_id !== 2'd0 || resp_q !== 64'h0000010000000010) begin
      failures++;
      $display("FAIL midreset_resp id=%0d q=%h exp 0/0000010000000010", resp_id, resp_q);
    end
    resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0;
    $display("reset_mid_wait: requester 0 granted first after reset");
  endtask

`ifdef DIV_SHARE_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    mute = 1'b1;
    set_op(2, 32'd5, 32'd1);
    @(negedge clk); req = 4'b0100;
    @(negedge clk); req = '0; #1;
    checks++;
    if (div_ld !== 1'b1) begin failures++; $display("FAIL tmo_load ld=%b exp=1", div_ld); end
    k = 0;
    while (!resp_valid && k < 100) begin @(negedge clk); #1; k++; end
    checks++;
    if (k !== 64 || resp_err !== 1'b1 || resp_q !== 64'd0) begin
      failures++;
      $display("FAIL tmo_resp cycles=%0d err=%b q=%h exp 64/1/0", k, resp_err, resp_q);
    end
    spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0; #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_q !== 64'd0) begin
      failures++;
      $display("FAIL tmo_late_done valid=%b err=%b q=%h exp 1/1/0", resp_valid, resp_err, resp_q);
    end
    resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0; #1;
    checks++;
    if (resp_err !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear err=%b valid=%b exp 0/0", resp_err, resp_valid);
    end
    mute = 1'b0;
    $display("timeout: watchdog response after %0d cycles", k);
  endtask
`endif

  initial begin
    rst = 1'b1;
    req = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    spur_done = 1'b0;
    mute = 1'b0;
    div_q = '0;
    div_lzcnt = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_dvz();
    test_backpressure();
    test_reset_mid_wait();
`ifdef DIV_SHARE_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
